// File: rtl/bitsel_cfg_pkg.sv
// Shared types and constants for the bitsel AXI4-Lite config master.
// State encoding, AXI response codes and error-code values.
package bitsel_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WB,
    S_RA,
    S_RD,
    S_CMP,
    S_FAIL,
    S_FIN
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_RESP = 2'd1;
  localparam logic [1:0] ERR_DATA = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/axil_wr_chan.sv
// Independent AW/W valid tracking for a single AXI4-Lite write.
// Both valids rise together on load and each clears after its own handshake.
module axil_wr_chan (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic abort_i,
  input  logic awready_i,
  input  logic wready_i,
  output logic awvalid_o,
  output logic wvalid_o,
  output logic done_o
);

  logic aw_pend_q, aw_pend_d;
  logic w_pend_q, w_pend_d;

  always_comb begin
    aw_pend_d = aw_pend_q & ~awready_i;
    w_pend_d  = w_pend_q & ~wready_i;
    if (load_i) begin
      aw_pend_d = 1'b1;
      w_pend_d  = 1'b1;
    end
    if (abort_i) begin
      aw_pend_d = 1'b0;
      w_pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
    end
  end

  assign awvalid_o = aw_pend_q;
  assign wvalid_o  = w_pend_q;
  // Both channels finished once each is idle or completing this cycle.
  assign done_o = (~aw_pend_q | awready_i) & (~w_pend_q | wready_i);

endmodule

// File: rtl/bitsel_cfg_master.sv
// AXI4-Lite master: writes config words to the bitsel slave,
// reads each back, and reports pass or the first failure.
module bitsel_cfg_master
  import bitsel_cfg_pkg::*;
#(
  parameter int                    NUM_ENTRIES    = 4,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    TIMEOUT_CYCLES = 256
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              start,
  input  logic [NUM_ENTRIES*DATA_WIDTH-1:0] cfg_data,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [3:0]                        err_idx,
  output logic [1:0]                        err_code,
  output logic [ADDR_WIDTH-1:0]             m_axi_awaddr,
  output logic [2:0]                        m_axi_awprot,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [DATA_WIDTH-1:0]             m_axi_wdata,
  output logic [3:0]                        m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [ADDR_WIDTH-1:0]             m_axi_araddr,
  output logic [2:0]                        m_axi_arprot,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [DATA_WIDTH-1:0]             m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  localparam int CW = NUM_ENTRIES * DATA_WIDTH;
  localparam int SW = (CW > 1) ? $clog2(CW) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] LAST = 4'(NUM_ENTRIES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic pass_q, pass_d;
  logic [3:0] err_idx_q, err_idx_d;
  logic [1:0] err_code_q, err_code_d;

  logic wr_load, wr_abort, wr_done;
  logic fail;
  logic [1:0] fail_code;
  logic tmo_hit, waiting;
  logic [3:0] idx_inc;
  logic [SW-1:0] sel_inc;
  logic [DATA_WIDTH-1:0] word0, word_inc;
  logic [ADDR_WIDTH-1:0] addr;

  assign idx_inc  = idx_q + 4'd1;
  assign sel_inc  = SW'({idx_inc, 5'b00000});
  assign word_inc = cfg_data[sel_inc +: DATA_WIDTH];
  assign word0    = cfg_data[DATA_WIDTH-1:0];
  assign tmo_hit  = (tmo_q == TMO_LAST);

  axil_wr_chan u_wr_chan (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .load_i    (wr_load),
    .abort_i   (wr_abort),
    .awready_i (m_axi_awready),
    .wready_i  (m_axi_wready),
    .awvalid_o (m_axi_awvalid),
    .wvalid_o  (m_axi_wvalid),
    .done_o    (wr_done)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    pass_d     = pass_q;
    err_idx_d  = err_idx_q;
    err_code_d = err_code_q;
    wr_load    = 1'b0;
    wr_abort   = 1'b0;
    fail       = 1'b0;
    fail_code  = ERR_NONE;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d      = 4'd0;
          wdata_d    = word0;
          pass_d     = 1'b0;
          err_idx_d  = 4'd0;
          err_code_d = ERR_NONE;
          wr_load    = 1'b1;
          state_d    = S_WR;
        end
      end
      S_WR: begin
        if (wr_done) begin
          state_d = S_WB;
        end else if (tmo_hit) begin
          fail      = 1'b1;
          fail_code = ERR_TMO;
          wr_abort  = 1'b1;
        end
      end
      S_WB: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != RESP_OKAY) begin
            fail      = 1'b1;
            fail_code = ERR_RESP;
          end else begin
            state_d = S_RA;
          end
        end else if (tmo_hit) begin
          fail      = 1'b1;
          fail_code = ERR_TMO;
        end
      end
      S_RA: begin
        if (m_axi_arready) begin
          state_d = S_RD;
        end else if (tmo_hit) begin
          fail      = 1'b1;
          fail_code = ERR_TMO;
        end
      end
      S_RD: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          if (m_axi_rresp != RESP_OKAY) begin
            fail      = 1'b1;
            fail_code = ERR_RESP;
          end else begin
            state_d = S_CMP;
          end
        end else if (tmo_hit) begin
          fail      = 1'b1;
          fail_code = ERR_TMO;
        end
      end
      S_CMP: begin
        if (rdata_q != wdata_q) begin
          fail      = 1'b1;
          fail_code = ERR_DATA;
        end else if (idx_q == LAST) begin
          pass_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          idx_d   = idx_inc;
          wdata_d = word_inc;
          wr_load = 1'b1;
          state_d = S_WR;
        end
      end
      S_FAIL: state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fail) begin
      state_d    = S_FAIL;
      err_idx_d  = idx_q;
      err_code_d = fail_code;
      pass_d     = 1'b0;
    end
  end

  // Handshake wait counter restarts whenever the state changes.
  assign waiting = (state_q == S_WR) || (state_q == S_WB) ||
                   (state_q == S_RA) || (state_q == S_RD);

  always_comb begin
    tmo_d = '0;
    if (waiting && (state_d == state_q)) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      tmo_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      pass_q     <= 1'b0;
      err_idx_q  <= 4'd0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      pass_q     <= pass_d;
      err_idx_q  <= err_idx_d;
      err_code_q <= err_code_d;
    end
  end

  assign addr = BASE_ADDR + ADDR_WIDTH'({idx_q, 2'b00});

  assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done     = (state_q == S_FIN);
  assign pass     = pass_q;
  assign err_idx  = err_idx_q;
  assign err_code = err_code_q;

  assign m_axi_awaddr  = addr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_bready  = (state_q == S_WB);
  assign m_axi_araddr  = addr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (state_q == S_RA);
  assign m_axi_rready  = (state_q == S_RD);

endmodule

// File: doc/bitsel_cfg_master.md
Name: bitsel_cfg_master

Overview:
- Synthesizable AXI4-Lite master that sits directly upstream of the bitsel S00_AXI slave and drives its register port.
- On a start pulse, writes NUM_ENTRIES config words to consecutive registers (BASE_ADDR + 4*i).
- Reads each register back after writing it and compares against the written value.
- Reports done/pass and, on failure, the failing index and cause. Used for power-up configuration and built-in self-check without a processor.

Parameters:
- NUM_ENTRIES, 4, number of registers written and checked (1..16)
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (fixed 32; WSTRB = 4'hF)
- BASE_ADDR, 32'h0000_0000, address of register 0
- TIMEOUT_CYCLES, 256, maximum wait per AXI channel handshake before abort

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous active-high reset
- start  in  1  single-cycle pulse; ignored unless idle
- cfg_data  in  NUM_ENTRIES*DATA_WIDTH  entry i at bits [32i+31:32i]; sampled per entry at write issue
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- pass  out  1  result of last sequence; held until next start
- err_idx  out  4  index of first failing entry
- err_code  out  2  0=none, 1=bad BRESP/RRESP, 2=data mismatch, 3=timeout
- m_axi_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1;  m_axi_awready  in  1
- m_axi_wdata/wstrb/wvalid  out  DATA_WIDTH/4/1;  m_axi_wready  in  1
- m_axi_bresp  in  2;  m_axi_bvalid  in  1;  m_axi_bready  out  1
- m_axi_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1;  m_axi_arready  in  1
- m_axi_rdata  in  DATA_WIDTH;  m_axi_rresp  in  2;  m_axi_rvalid  in  1;  m_axi_rready  out  1

Behaviour:
- Reset (async assert, sync release to ACLK): all valid/ready outputs 0, busy=0, done=0, pass=0, err_idx=0, err_code=0, FSM=IDLE, idx=0. Any in-flight transaction is abandoned; no recovery is attempted.
- awprot = arprot = 3'b000. Addresses: BASE_ADDR + {idx,2'b00}.
- IDLE:
  - On start: busy=1, idx=0, err_code=0, pass=0, go to WR.
  - start while busy is ignored.
- WR:
  - awvalid and wvalid assert together (same cycle) and stay registered.
  - Each deasserts independently the cycle after its own handshake; AW and W may complete in either order or simultaneously.
  - Address and data must not change while valid is high.
  - Exit to WB when both handshakes are done.
- WB:
  - bready=1. On bvalid: bresp!=OKAY -> FAIL(code 1); else go to RA.
- RA: arvalid=1 until arready, then go to RD.
- RD: rready=1. On rvalid, capture rdata; rresp!=OKAY -> FAIL(1); else go to CMP.
- CMP (1 cycle): rdata!=cfg word -> FAIL(2).
  - Else if idx==NUM_ENTRIES-1, go to FIN with pass=1.
  - Else idx+1 and go to WR.
- Timeout:
  - Per-state counter, cleared on state entry.
  - Reaching TIMEOUT_CYCLES in WR/WB/RA/RD -> FAIL(3).
  - Valids drop on abort (documented AXI violation, acceptable for self-test).
- FAIL: err_idx=idx, err_code latched, pass=0, go to FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Latency, zero-wait slave, per entry: WR 1 + WB 1 + RA 1 + RD 1 + CMP 1 = 5 cycles. Full sequence = 5*NUM_ENTRIES + 1 cycles from start to done.
- Only one outstanding transaction at any time. Write completes before its read-back.

Decomposition:
- Package bitsel_cfg_pkg holds:
  - FSM state enum (IDLE, WR, WB, RA, RD, CMP, FAIL, FIN)
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01
  - err_code constants
- Sub-module axil_wr_chan tracks the independent AW/W valid/handshake-done flags.
- Everything else is in the top module.

Test Plan:
- Data {0101FFFF, abcd0001, dead0011, beef0011} to the bitsel slave (zero-wait) -> four write/read pairs at +0,+4,+8,+C; done after 21 cycles; pass=1; err_code=0.
- Slave asserts wready 3 cycles before awready, then the reverse on the next entry -> both orders accepted; each valid drops the cycle after its own handshake; pass=1.
- Slave returns bresp=2'b10 on entry 2 -> no AR issued for entry 2; done; pass=0; err_idx=2; err_code=1.
- Slave corrupts rdata bit 0 on entry 1 (returns abcd0000) -> pass=0; err_idx=1; err_code=2.
- arready held low forever on entry 0 -> abort after 256 cycles in RA; err_code=3; arvalid=0 afterwards.
- ARESET pulsed mid-WB, then start re-issued -> outputs at reset values immediately; second run completes with pass=1. A start pulse during busy has no effect.
